// File: rtl/wb_commit_stage_pkg.sv
// Shared sizing helpers for the writeback/commit stage and its trace FIFO.
// Trace entry layout is {pc, we, waddr, wdata}; HI/LO bus is {hi_wdata, lo_wdata, hi_we, lo_we}.
package wb_commit_stage_pkg;

  function automatic int unsigned trace_entry_w(input int unsigned pc_w,
                                                input int unsigned addr_w,
                                                input int unsigned data_w);
    return pc_w + 1 + addr_w + data_w;
  endfunction

  function automatic int unsigned hilo_w(input int unsigned data_w);
    return 2 * data_w + 2;
  endfunction

endpackage

// File: rtl/wb_trace_fifo.sv
// Circular trace FIFO: up to LANES compacted pushes and one pop per cycle.
// The head is popped every cycle the FIFO is non-empty; head reads as zero when empty.
module wb_trace_fifo #(
  parameter int unsigned LANES   = 2,
  parameter int unsigned ENTRY_W = 70,
  parameter int unsigned DEPTH   = 8
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [$clog2(LANES+1)-1:0]       push_cnt,
  input  logic [LANES*ENTRY_W-1:0]         push_data,
  output logic [ENTRY_W-1:0]               head,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
  localparam int unsigned PCNT_W = $clog2(LANES + 1);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wptr;
  logic [PTR_W-1:0]   rptr;
  logic               pop;

  assign pop  = (count != '0);
  assign head = pop ? mem[rptr] : '0;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      wptr  <= wptr + PTR_W'(push_cnt);
      rptr  <= rptr + PTR_W'(pop);
      count <= count + CNT_W'(push_cnt) - CNT_W'(pop);
    end
  end

  // Pushed entries arrive already compacted: slot s goes to wptr+s.
  always_ff @(posedge clk) begin
    for (int unsigned s = 0; s < LANES; s++) begin
      if (PCNT_W'(s) < push_cnt)
        mem[wptr + PTR_W'(s)] <= push_data[s*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: rtl/wb_commit_stage.sv
// Multi-lane writeback/commit register with $0/WAW write filtering and a serialised debug trace.
// Optional HI/LO writeback path is enabled by defining WB_HILO_EN.
module wb_commit_stage
  import wb_commit_stage_pkg::*;
#(
  parameter int unsigned LANES       = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 5,
  parameter int unsigned PC_W        = 32,
  parameter int unsigned TRACE_DEPTH = 8
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES-1:0]          in_lane_vld,
  input  logic [LANES-1:0]          in_lane_we,
  input  logic [LANES*ADDR_W-1:0]   in_lane_waddr,
  input  logic [LANES*DATA_W-1:0]   in_lane_wdata,
  input  logic [LANES*PC_W-1:0]     in_lane_pc,
  output logic [LANES-1:0]          rf_we,
  output logic [LANES*ADDR_W-1:0]   rf_waddr,
  output logic [LANES*DATA_W-1:0]   rf_wdata,
`ifdef WB_HILO_EN
  input  logic [hilo_w(DATA_W)-1:0] in_hilo,
  output logic                      hi_we,
  output logic                      lo_we,
  output logic [DATA_W-1:0]         hi_wdata,
  output logic [DATA_W-1:0]         lo_wdata,
`endif
  output logic [PC_W-1:0]           debug_wb_pc,
  output logic [3:0]                debug_wb_rf_wen,
  output logic [ADDR_W-1:0]         debug_wb_rf_wnum,
  output logic [DATA_W-1:0]         debug_wb_rf_wdata,
  output logic                      trace_full
);
  localparam int unsigned ENTRY_W = trace_entry_w(PC_W, ADDR_W, DATA_W);
  localparam int unsigned CNT_W   = $clog2(TRACE_DEPTH + 1);
  localparam int unsigned PCNT_W  = $clog2(LANES + 1);

  logic                    accept;
  logic [LANES-1:0]        lane_wr;
  logic [LANES-1:0]        lane_commit;

  logic [LANES-1:0]        b_vld;
  logic [LANES-1:0]        b_wr;
  logic [LANES*ADDR_W-1:0] b_waddr;
  logic [LANES*DATA_W-1:0] b_wdata;
  logic [LANES*PC_W-1:0]   b_pc;

  logic [CNT_W-1:0]         fifo_count;
  logic [PCNT_W-1:0]        push_cnt;
  logic [LANES*ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0]       head;

  assign in_ready   = (fifo_count <= CNT_W'(TRACE_DEPTH - LANES));
  assign trace_full = ~in_ready;
  assign accept     = in_valid & in_ready & ~flush;

  // lane_wr is the trace-visible enable; lane_commit additionally drops a lane
  // when a younger lane of the same bundle writes the same register.
  always_comb begin
    lane_wr     = '0;
    lane_commit = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_wr[i] = in_lane_vld[i] & in_lane_we[i] &
                   (in_lane_waddr[i*ADDR_W +: ADDR_W] != '0);
    end
    for (int unsigned i = 0; i < LANES; i++) begin
      lane_commit[i] = lane_wr[i];
      for (int unsigned j = i + 1; j < LANES; j++) begin
        if (lane_wr[j] &&
            (in_lane_waddr[j*ADDR_W +: ADDR_W] == in_lane_waddr[i*ADDR_W +: ADDR_W]))
          lane_commit[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_vld   <= '0;
      b_wr    <= '0;
      b_waddr <= '0;
      b_wdata <= '0;
      b_pc    <= '0;
      rf_we   <= '0;
    end else if (accept) begin
      b_vld   <= in_lane_vld;
      b_wr    <= lane_wr;
      b_waddr <= in_lane_waddr;
      b_wdata <= in_lane_wdata;
      b_pc    <= in_lane_pc;
      rf_we   <= lane_commit;
    end else begin
      b_vld   <= '0;
      b_wr    <= '0;
      b_waddr <= '0;
      b_wdata <= '0;
      b_pc    <= '0;
      rf_we   <= '0;
    end
  end

  assign rf_waddr = b_waddr;
  assign rf_wdata = b_wdata;

`ifdef WB_HILO_EN
  logic [hilo_w(DATA_W)-1:0] hilo_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      hilo_q <= '0;
    else if (accept)
      hilo_q <= in_hilo;
    else
      hilo_q <= '0;
  end

  assign {hi_wdata, lo_wdata, hi_we, lo_we} = hilo_q;
`endif

  // Valid lanes of the registered bundle are packed, oldest first, into consecutive push slots.
  always_comb begin
    int unsigned slot;
    slot      = 0;
    push_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (b_vld[i]) begin
        push_data[slot*ENTRY_W +: ENTRY_W] = {b_pc[i*PC_W +: PC_W], b_wr[i],
                                              b_waddr[i*ADDR_W +: ADDR_W],
                                              b_wdata[i*DATA_W +: DATA_W]};
        slot = slot + 1;
      end
    end
    push_cnt = PCNT_W'(slot);
  end

  wb_trace_fifo #(
    .LANES   (LANES),
    .ENTRY_W (ENTRY_W),
    .DEPTH   (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push_cnt  (push_cnt),
    .push_data (push_data),
    .head      (head),
    .count     (fifo_count)
  );

  assign debug_wb_pc       = head[ENTRY_W-1 -: PC_W];
  assign debug_wb_rf_wen   = {4{head[ADDR_W+DATA_W]}};
  assign debug_wb_rf_wnum  = head[DATA_W +: ADDR_W];
  assign debug_wb_rf_wdata = head[DATA_W-1:0];

endmodule

// File: tb/tb_wb_commit_stage.sv
// Self-checking bench for wb_commit_stage: directed scenarios plus randomized traffic
// compared against a queue-based model of the retire/trace behaviour.
module tb_wb_commit_stage;
  localparam int unsigned L  = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned PW = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned DBG_W = PW + 4 + AW + DW;

  logic clk = 1'b0;
  logic resetn;
  logic flush, in_valid, in_ready;
  logic [L-1:0]    in_lane_vld, in_lane_we;
  logic [L*AW-1:0] in_lane_waddr;
  logic [L*DW-1:0] in_lane_wdata;
  logic [L*PW-1:0] in_lane_pc;
  logic [L-1:0]    rf_we;
  logic [L*AW-1:0] rf_waddr;
  logic [L*DW-1:0] rf_wdata;
`ifdef WB_HILO_EN
  logic [2*DW+1:0] in_hilo;
  logic            hi_we, lo_we;
  logic [DW-1:0]   hi_wdata, lo_wdata;
`endif
  logic [PW-1:0]   debug_wb_pc;
  logic [3:0]      debug_wb_rf_wen;
  logic [AW-1:0]   debug_wb_rf_wnum;
  logic [DW-1:0]   debug_wb_rf_wdata;
  logic            trace_full;

  always #5 clk = ~clk;

  wb_commit_stage #(
    .LANES(L), .DATA_W(DW), .ADDR_W(AW), .PC_W(PW), .TRACE_DEPTH(D)
  ) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_lane_we(in_lane_we), .in_lane_waddr(in_lane_waddr),
    .in_lane_wdata(in_lane_wdata), .in_lane_pc(in_lane_pc),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
`ifdef WB_HILO_EN
    .in_hilo(in_hilo), .hi_we(hi_we), .lo_we(lo_we), .hi_wdata(hi_wdata), .lo_wdata(lo_wdata),
`endif
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata),
    .trace_full(trace_full)
  );

  typedef struct {
    logic [PW-1:0] pc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t tq[$];    // entries currently held in the trace FIFO, head first
  ent_t pend[$];  // entries of the registered bundle, pushed at the next edge
  logic [L-1:0]    exp_we;
  logic [L*AW-1:0] exp_waddr;
  logic [L*DW-1:0] exp_wdata;
  logic            last_acc;
  int checks = 0;
  int errors = 0;

  function automatic logic [DBG_W-1:0] exp_dbg();
    if (tq.size() > 0)
      return {tq[0].pc, {4{tq[0].we}}, tq[0].addr, tq[0].data};
    return '0;
  endfunction

  function automatic logic [DBG_W-1:0] act_dbg();
    return {debug_wb_pc, debug_wb_rf_wen, debug_wb_rf_wnum, debug_wb_rf_wdata};
  endfunction

  task automatic clear_inputs();
    in_valid = 1'b0; flush = 1'b0;
    in_lane_vld = '0; in_lane_we = '0;
    in_lane_waddr = '0; in_lane_wdata = '0; in_lane_pc = '0;
`ifdef WB_HILO_EN
    in_hilo = '0;
`endif
  endtask

  task automatic set_lane(input int unsigned i, input logic v, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [PW-1:0] p);
    in_lane_vld[i] = v;
    in_lane_we[i]  = w;
    in_lane_waddr[i*AW +: AW] = a;
    in_lane_wdata[i*DW +: DW] = d;
    in_lane_pc[i*PW +: PW]    = p;
  endtask

  task automatic model_reset();
    tq.delete(); pend.delete();
    exp_we = '0; exp_waddr = '0; exp_wdata = '0;
    last_acc = 1'b1;
  endtask

  // One clock: model consumes the current inputs, then time moves 1 unit past the edge.
  task automatic advance();
    logic acc;
    ent_t e;
    int owner[int];
    acc = in_valid && !flush && (tq.size() <= int'(D - L));
    @(posedge clk);
    if (tq.size() > 0) e = tq.pop_front();
    while (pend.size() > 0) tq.push_back(pend.pop_front());
    exp_we = '0; exp_waddr = '0; exp_wdata = '0;
    if (acc) begin
      for (int unsigned i = 0; i < L; i++)
        if (in_lane_vld[i] && in_lane_we[i] && in_lane_waddr[i*AW +: AW] != 0)
          owner[int'(in_lane_waddr[i*AW +: AW])] = int'(i);
      for (int unsigned i = 0; i < L; i++) begin
        if (in_lane_vld[i]) begin
          e.pc   = in_lane_pc[i*PW +: PW];
          e.addr = in_lane_waddr[i*AW +: AW];
          e.data = in_lane_wdata[i*DW +: DW];
          e.we   = in_lane_we[i] && (e.addr != 0);
          pend.push_back(e);
          if (e.we && owner[int'(e.addr)] == int'(i)) begin
            exp_we[i] = 1'b1;
            exp_waddr[i*AW +: AW] = e.addr;
            exp_wdata[i*DW +: DW] = e.data;
          end
        end
      end
    end
    last_acc = acc;
    #1;
  endtask

  task automatic drain();
    clear_inputs();
    for (int k = 0; k < 4 * int'(D) && (tq.size() > 0 || pend.size() > 0); k++) advance();
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    model_reset();
    #12;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
      errors++; $display("FAIL reset_rf: got we=%b addr=%h data=%h, want all 0", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (act_dbg() !== '0) begin
      errors++; $display("FAIL reset_debug: got %h, want 0", act_dbg());
    end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || trace_full !== 1'b0 || debug_wb_rf_wen !== 4'h0) begin
      errors++; $display("FAIL reset_release: got ready=%b full=%b wen=%h, want 1 0 0", in_ready, trace_full, debug_wb_rf_wen);
    end
    // Mid-operation reset with a bundle in the register and one on the inputs.
    in_valid = 1'b1;
    set_lane(0, 1, 1, 5'd1, 32'hAAAA_0001, 32'h0000_0100);
    set_lane(1, 1, 1, 5'd2, 32'hAAAA_0002, 32'h0000_0104);
    advance();
    set_lane(0, 1, 1, 5'd3, 32'hAAAA_0003, 32'h0000_0108);
    set_lane(1, 1, 1, 5'd4, 32'hAAAA_0004, 32'h0000_010C);
    advance();
    checks++;
    if (rf_we !== 2'b11 || debug_wb_pc !== 32'h0000_0100) begin
      errors++; $display("FAIL reset_preload: got we=%b pc=%h, want 11 00000100", rf_we, debug_wb_pc);
    end
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== '0 || act_dbg() !== '0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_midop: got we=%b dbg=%h ready=%b, want 0 0 1", rf_we, act_dbg(), in_ready);
    end
    model_reset();
    clear_inputs();
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rf_we !== '0 || debug_wb_rf_wen !== 4'h0 || act_dbg() !== '0) begin
        errors++; $display("FAIL reset_no_partial: cycle %0d got we=%b dbg=%h, want 0 0", k, rf_we, act_dbg());
      end
      advance();
    end
  endtask

  task automatic test_dual_retire();
    drain();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 5'd3, 32'h11, 32'hBFC0_0000);
    set_lane(1, 1, 1, 5'd4, 32'h22, 32'hBFC0_0004);
    advance();
    clear_inputs();
    checks++;
    if (rf_we !== 2'b11 || rf_waddr !== {5'd4, 5'd3} || rf_wdata !== {32'h22, 32'h11}) begin
      errors++; $display("FAIL dual_rf: got we=%b addr=%h data=%h, want 11 083 0000002200000011", rf_we, rf_waddr, rf_wdata);
    end
    checks++;
    if (debug_wb_rf_wen !== 4'h0) begin
      errors++; $display("FAIL dual_no_bypass: got wen=%h, want 0", debug_wb_rf_wen);
    end
    advance();
    checks++;
    if (act_dbg() !== {32'hBFC0_0000, 4'hF, 5'd3, 32'h11}) begin
      errors++; $display("FAIL dual_trace0: got %h, want pc bfc00000 r3 11", act_dbg());
    end
    advance();
    checks++;
    if (act_dbg() !== {32'hBFC0_0004, 4'hF, 5'd4, 32'h22}) begin
      errors++; $display("FAIL dual_trace1: got %h, want pc bfc00004 r4 22", act_dbg());
    end
    advance();
    checks++;
    if (act_dbg() !== '0) begin
      errors++; $display("FAIL dual_empty: got %h, want 0", act_dbg());
    end
  endtask

  task automatic test_waw_zero();
    drain();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 5'd5, 32'hA, 32'h0000_2000);
    set_lane(1, 1, 1, 5'd5, 32'hB, 32'h0000_2004);
    advance();
    set_lane(0, 1, 1, 5'd0, 32'h33, 32'h0000_2008);
    set_lane(1, 1, 1, 5'd7, 32'h44, 32'h0000_200C);
    checks++;
    if (rf_we !== 2'b10 || rf_waddr[2*AW-1:AW] !== 5'd5 || rf_wdata[2*DW-1:DW] !== 32'hB) begin
      errors++; $display("FAIL waw_rf: got we=%b addr1=%h data1=%h, want 10 05 0000000b", rf_we, rf_waddr[2*AW-1:AW], rf_wdata[2*DW-1:DW]);
    end
    advance();
    clear_inputs();
    checks++;
    if (rf_we !== 2'b10 || rf_waddr[2*AW-1:AW] !== 5'd7 || rf_wdata[2*DW-1:DW] !== 32'h44) begin
      errors++; $display("FAIL zero_rf: got we=%b addr1=%h data1=%h, want 10 07 00000044", rf_we, rf_waddr[2*AW-1:AW], rf_wdata[2*DW-1:DW]);
    end
    checks++;
    if (act_dbg() !== {32'h0000_2000, 4'hF, 5'd5, 32'hA}) begin
      errors++; $display("FAIL waw_trace0: got %h, want suppressed lane traced with wen f", act_dbg());
    end
    advance();
    checks++;
    if (act_dbg() !== {32'h0000_2004, 4'hF, 5'd5, 32'hB}) begin
      errors++; $display("FAIL waw_trace1: got %h, want pc 2004 r5 b", act_dbg());
    end
    advance();
    checks++;
    if (act_dbg() !== {32'h0000_2008, 4'h0, 5'd0, 32'h33}) begin
      errors++; $display("FAIL zero_trace: got %h, want pc 2008 wen 0 r0 33", act_dbg());
    end
    advance();
    checks++;
    if (act_dbg() !== {32'h0000_200C, 4'hF, 5'd7, 32'h44}) begin
      errors++; $display("FAIL zero_trace1: got %h, want pc 200c r7 44", act_dbg());
    end
  endtask

  task automatic test_flush();
    drain();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 5'd9,  32'h99, 32'h0000_1000);
    set_lane(1, 1, 1, 5'd10, 32'hAA, 32'h0000_1004);
    advance();
    flush = 1'b1;
    set_lane(0, 1, 1, 5'd11, 32'hBB, 32'h0000_3000);
    set_lane(1, 1, 1, 5'd12, 32'hCC, 32'h0000_3004);
    checks++;
    if (rf_we !== 2'b11 || rf_wdata !== {32'hAA, 32'h99}) begin
      errors++; $display("FAIL flush_prior: got we=%b data=%h, want 11 000000aa00000099", rf_we, rf_wdata);
    end
    advance();
    clear_inputs();
    checks++;
    if (rf_we !== 2'b00) begin
      errors++; $display("FAIL flush_bubble: got we=%b, want 00", rf_we);
    end
    checks++;
    if (act_dbg() !== {32'h0000_1000, 4'hF, 5'd9, 32'h99}) begin
      errors++; $display("FAIL flush_trace0: got %h, want pc 1000 r9 99", act_dbg());
    end
    advance();
    advance();
    checks++;
    if (act_dbg() !== '0) begin
      errors++; $display("FAIL flush_not_traced: got %h, want 0", act_dbg());
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] pc_ctr;
    int stall_cycles;
    drain();
    pc_ctr = 32'h8000_0000;
    stall_cycles = 0;
    last_acc = 1'b1;
    for (int c = 0; c < 300; c++) begin
      if (last_acc || flush || !in_valid) begin
        for (int unsigned i = 0; i < L; i++) begin
          set_lane(i, ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   AW'($urandom_range(0, 7)), $urandom, pc_ctr);
          pc_ctr = pc_ctr + 4;
        end
      end
      in_valid = (c < 260) && ($urandom_range(0, 7) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      advance();
      if (in_ready === 1'b0) stall_cycles++;
      checks++;
      if (in_ready !== (tq.size() <= int'(D - L)) || trace_full !== (tq.size() > int'(D - L))) begin
        errors++; $display("FAIL bp_ready: cycle %0d got ready=%b full=%b, want model count %0d", c, in_ready, trace_full, tq.size());
      end
      checks++;
      if (rf_we !== exp_we) begin
        errors++; $display("FAIL bp_rf_we: cycle %0d got %b, want %b", c, rf_we, exp_we);
      end
      for (int unsigned i = 0; i < L; i++) begin
        if (exp_we[i]) begin
          checks++;
          if (rf_waddr[i*AW +: AW] !== exp_waddr[i*AW +: AW] || rf_wdata[i*DW +: DW] !== exp_wdata[i*DW +: DW]) begin
            errors++; $display("FAIL bp_rf_lane%0d: cycle %0d got %h/%h, want %h/%h", i, c,
              rf_waddr[i*AW +: AW], rf_wdata[i*DW +: DW], exp_waddr[i*AW +: AW], exp_wdata[i*DW +: DW]);
          end
        end
      end
      checks++;
      if (act_dbg() !== exp_dbg()) begin
        errors++; $display("FAIL bp_trace: cycle %0d got %h, want %h", c, act_dbg(), exp_dbg());
      end
    end
    checks++;
    if (stall_cycles == 0) begin
      errors++; $display("FAIL bp_stall_seen: got 0 not-ready cycles, want at least 1");
    end
  endtask

`ifdef WB_HILO_EN
  task automatic test_hilo();
    drain();
    in_valid = 1'b1;
    set_lane(0, 1, 1, 5'd1, 32'h1, 32'h0000_4000);
    in_hilo = {32'h1, 32'h2, 1'b1, 1'b1};
    advance();
    clear_inputs();
    checks++;
    if ({hi_wdata, lo_wdata, hi_we, lo_we} !== {32'h1, 32'h2, 1'b1, 1'b1}) begin
      errors++; $display("FAIL hilo_write: got hi=%h lo=%h we=%b%b, want 1 2 11", hi_wdata, lo_wdata, hi_we, lo_we);
    end
    advance();
    checks++;
    if ({hi_we, lo_we} !== 2'b00) begin
      errors++; $display("FAIL hilo_bubble: got we=%b%b, want 00", hi_we, lo_we);
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_dual_retire();
    test_waw_zero();
    test_flush();
    test_backpressure();
`ifdef WB_HILO_EN
    test_hilo();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
